// File: rtl/rv32i_pkg.sv
// Shared RV32I decode encodings for the decode and execute stages.
// Holds opcodes, ALU operations, result-source codes and the ID/EX payload.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_Z,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] result_src;
    alu_op_e    alu;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    ctrl_t       ctrl;
    logic [2:0]  funct3;
  } id_ex_t;

  // Register ops honour funct7[5] for SUB; immediate ops only for SRAI.
  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt,
                                      input logic reg_op);
    alu_op_e op;
    case (f3)
      3'b000:  op = (alt && reg_op) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: x0 hardwired to zero, combinational reads,
// optional same-cycle forwarding of the writeback port.
module regfile #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] mem [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) mem[k] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  // The zero-address test comes first so a write to x0 is never forwarded.
  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 :
                  (BYPASS && we && (waddr == raddr1)) ? wdata : mem[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 :
                  (BYPASS && we && (waddr == raddr2)) ? wdata : mem[raddr2];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register read, control decode, immediate generation
// and the ID/EX pipeline register with flush.
module id_stage
  import rv32i_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcAE,
  output logic        ALUSrcBE,
  output logic [1:0]  ResultSrcE,
  output logic [3:0]  ALUControlE,
  output logic [2:0]  Funct3E
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm;
  imm_sel_e    imm_sel;
  ctrl_t       ctrl;
  id_ex_t      id_ex;

  assign opcode    = InstrD[6:0];
  assign funct3    = InstrD[14:12];
  assign funct7_b5 = InstrD[30];
  assign Rs1D      = InstrD[19:15];
  assign Rs2D      = InstrD[24:20];

  regfile #(.BYPASS(WB_BYPASS)) u_regfile (
    .clk    (CLK),
    .rst_n  (RST),
    .we     (RegWriteW),
    .waddr  (RdW),
    .wdata  (ResultW),
    .raddr1 (Rs1D),
    .raddr2 (Rs2D),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // Unrecognised opcodes fall through to the all-zero control word (bubble).
  always_comb begin
    ctrl    = '0;
    imm_sel = IMM_Z;
    case (opcode)
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu       = alu_dec(funct3, funct7_b5, 1'b1);
      end
      OPC_OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu       = alu_dec(funct3, funct7_b5, 1'b0);
        imm_sel        = IMM_I;
      end
      OPC_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_MEM;
        imm_sel         = IMM_I;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm_sel        = IMM_S;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu    = ALU_SUB;
        imm_sel     = IMM_B;
      end
      OPC_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_sel         = IMM_J;
      end
      OPC_JALR: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_sel         = IMM_I;
      end
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu       = ALU_PASSB;
        imm_sel        = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm_sel        = IMM_U;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I:   imm = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                      InstrD[11:8], 1'b0};
      IMM_U:   imm = {InstrD[31:12], 12'b0};
      IMM_J:   imm = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                      InstrD[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      id_ex <= '0;
    end else if (FlushE) begin
      id_ex <= '0;
    end else begin
      id_ex.rd1      <= rd1;
      id_ex.rd2      <= rd2;
      id_ex.imm      <= imm;
      id_ex.pc       <= PCD;
      id_ex.pc_plus4 <= PCPlus4D;
      id_ex.rs1      <= Rs1D;
      id_ex.rs2      <= Rs2D;
      id_ex.rd       <= InstrD[11:7];
      id_ex.ctrl     <= ctrl;
      id_ex.funct3   <= funct3;
    end
  end

  assign RD1E        = id_ex.rd1;
  assign RD2E        = id_ex.rd2;
  assign ImmExtE     = id_ex.imm;
  assign PCE         = id_ex.pc;
  assign PCPlus4E    = id_ex.pc_plus4;
  assign Rs1E        = id_ex.rs1;
  assign Rs2E        = id_ex.rs2;
  assign RdE         = id_ex.rd;
  assign RegWriteE   = id_ex.ctrl.reg_write;
  assign MemWriteE   = id_ex.ctrl.mem_write;
  assign JumpE       = id_ex.ctrl.jump;
  assign BranchE     = id_ex.ctrl.branch;
  assign ALUSrcAE    = id_ex.ctrl.alu_src_a;
  assign ALUSrcBE    = id_ex.ctrl.alu_src_b;
  assign ResultSrcE  = id_ex.ctrl.result_src;
  assign ALUControlE = id_ex.ctrl.alu;
  assign Funct3E     = id_ex.funct3;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized instructions
// checked against an arithmetic decode model; a second instance has no bypass.
module tb_id_stage;

  logic        CLK;
  logic        RST;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        FlushE, RegWriteW;
  logic [4:0]  RdW;

  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;

  logic [4:0]  Rs1D_n, Rs2D_n, Rs1E_n, Rs2E_n, RdE_n;
  logic [31:0] RD1E_n, RD2E_n, ImmExtE_n, PCE_n, PCPlus4E_n;
  logic        RegWriteE_n, MemWriteE_n, JumpE_n, BranchE_n, ALUSrcAE_n, ALUSrcBE_n;
  logic [1:0]  ResultSrcE_n;
  logic [3:0]  ALUControlE_n;
  logic [2:0]  Funct3E_n;

  id_stage dut (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E)
  );

  id_stage #(.WB_BYPASS(1'b0)) dut_nb (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D_n), .Rs2D(Rs2D_n), .RD1E(RD1E_n), .RD2E(RD2E_n),
    .ImmExtE(ImmExtE_n), .PCE(PCE_n), .PCPlus4E(PCPlus4E_n), .Rs1E(Rs1E_n),
    .Rs2E(Rs2E_n), .RdE(RdE_n), .RegWriteE(RegWriteE_n),
    .MemWriteE(MemWriteE_n), .JumpE(JumpE_n), .BranchE(BranchE_n),
    .ALUSrcAE(ALUSrcAE_n), .ALUSrcBE(ALUSrcBE_n), .ResultSrcE(ResultSrcE_n),
    .ALUControlE(ALUControlE_n), .Funct3E(Funct3E_n)
  );

  wire [189:0] e_bus = {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
                        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE,
                        ResultSrcE, ALUControlE, Funct3E};
  wire [189:0] e_bus_n = {RD1E_n, RD2E_n, ImmExtE_n, PCE_n, PCPlus4E_n, Rs1E_n,
                          Rs2E_n, RdE_n, RegWriteE_n, MemWriteE_n, JumpE_n,
                          BranchE_n, ALUSrcAE_n, ALUSrcBE_n, ResultSrcE_n,
                          ALUControlE_n, Funct3E_n};

  int errors = 0;
  int checks = 0;

  logic [31:0]  regs_m [32];
  logic         pend_we;
  logic [4:0]   pend_rd;
  logic [31:0]  pend_res;
  logic [189:0] exp_bus, exp_bus_n;

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_rd(input logic [4:0] a, input logic byp);
    if (a == 5'd0) return 32'd0;
    if (byp && pend_we && (pend_rd == a)) return pend_res;
    return regs_m[a];
  endfunction

  function automatic logic [189:0] model_e(input logic [31:0] i, input logic [31:0] pc,
                                           input logic [31:0] pc4, input logic [31:0] r1,
                                           input logic [31:0] r2);
    logic regw, memw, jmp, br, asa, asb;
    logic [1:0] res;
    logic [3:0] alu;
    int neg;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic [3:0] alu_tab [8];
    alu_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    neg   = i[31] ? 1 : 0;
    imm_i = 32'(-2048 * neg + int'(i[30:20]));
    imm_s = 32'(-2048 * neg + int'(i[30:25]) * 32 + int'(i[11:7]));
    imm_b = 32'(-4096 * neg + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2);
    imm_u = i & 32'hFFFF_F000;
    imm_j = 32'(-1048576 * neg + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                + int'(i[30:21]) * 2);
    {regw, memw, jmp, br, asa, asb} = 6'b0;
    res = 2'd0; alu = 4'd0; imm = 32'd0;
    case (i[6:0])
      7'h33: begin regw = 1; alu = alu_tab[i[14:12]];
             if (i[30] && i[14:12] == 3'd0) alu = 4'd1;
             if (i[30] && i[14:12] == 3'd5) alu = 4'd7; end
      7'h13: begin regw = 1; asb = 1; imm = imm_i; alu = alu_tab[i[14:12]];
             if (i[30] && i[14:12] == 3'd5) alu = 4'd7; end
      7'h03: begin regw = 1; asb = 1; res = 2'd1; imm = imm_i; end
      7'h23: begin memw = 1; asb = 1; imm = imm_s; end
      7'h63: begin br = 1; alu = 4'd1; imm = imm_b; end
      7'h6F: begin jmp = 1; regw = 1; res = 2'd2; imm = imm_j; end
      7'h67: begin jmp = 1; regw = 1; asb = 1; res = 2'd2; imm = imm_i; end
      7'h37: begin regw = 1; asb = 1; alu = 4'd10; imm = imm_u; end
      7'h17: begin regw = 1; asa = 1; asb = 1; imm = imm_u; end
      default: ;
    endcase
    return {r1, r2, imm, pc, pc4, i[19:15], i[24:20], i[11:7],
            regw, memw, jmp, br, asa, asb, res, alu, i[14:12]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic [31:0] instr, input logic flush, input logic we,
                            input logic [4:0] rd, input logic [31:0] res);
    InstrD = instr;
    PCD = $urandom();
    PCD[1:0] = 2'b00;
    PCPlus4D = PCD + 32'd4;
    FlushE = flush;
    RegWriteW = we;
    RdW = rd;
    ResultW = res;
    pend_we = we; pend_rd = rd; pend_res = res;
    exp_bus   = flush ? '0 : model_e(instr, PCD, PCPlus4D,
                                     model_rd(instr[19:15], 1'b1), model_rd(instr[24:20], 1'b1));
    exp_bus_n = flush ? '0 : model_e(instr, PCD, PCPlus4D,
                                     model_rd(instr[19:15], 1'b0), model_rd(instr[24:20], 1'b0));
  endtask

  task automatic tick();
    @(posedge CLK);
    if (pend_we && pend_rd != 5'd0) regs_m[pend_rd] = pend_res;
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 32; k++) regs_m[k] = 32'd0;
    pend_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0;
    clear_model();
    set_inputs(32'h00A5_8533, 1'b0, 1'b1, 5'd3, 32'h1111_2222);
    #1;
    checks++; if (e_bus !== '0) begin errors++; $display("FAIL reset_bus: got %h want 0", e_bus); end
    checks++; if (Rs1D !== 5'd11 || Rs2D !== 5'd10) begin errors++;
      $display("FAIL reset_rs_comb: got %0d/%0d want 11/10", Rs1D, Rs2D); end
    @(posedge CLK); #1;
    checks++; if (e_bus_n !== '0) begin errors++; $display("FAIL reset_hold_nb: got %h want 0", e_bus_n); end
    @(negedge CLK);
    RST = 1'b1;
    clear_model();
  endtask

  task automatic test_write_read();
    set_inputs(32'h0000_0013, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    set_inputs(32'h0002_80B3, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (RD1E !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd1: got %h want deadbeef", RD1E); end
    checks++; if (ALUControlE !== 4'b0000) begin errors++; $display("FAIL wr_alu: got %b want 0000", ALUControlE); end
    checks++; if (RegWriteE !== 1'b1 || RdE !== 5'd1) begin errors++;
      $display("FAIL wr_ctl: got rw=%b rd=%0d want rw=1 rd=1", RegWriteE, RdE); end
    checks++; if (e_bus !== exp_bus) begin errors++; $display("FAIL wr_bus: got %h want %h", e_bus, exp_bus); end
  endtask

  task automatic test_bypass();
    logic [31:0] old;
    set_inputs(32'h0000_0013, 1'b0, 1'b1, 5'd7, 32'h0BAD_F00D);
    tick();
    old = regs_m[7];
    set_inputs(32'h0073_8133, 1'b0, 1'b1, 5'd7, 32'h1234_5678);
    tick();
    checks++; if (RD1E !== 32'h1234_5678 || RD2E !== 32'h1234_5678) begin errors++;
      $display("FAIL byp_on: got %h/%h want 12345678", RD1E, RD2E); end
    checks++; if (RD1E_n !== old) begin errors++; $display("FAIL byp_off: got %h want %h", RD1E_n, old); end
    checks++; if (e_bus_n !== exp_bus_n) begin errors++; $display("FAIL byp_off_bus: got %h want %h", e_bus_n, exp_bus_n); end
  endtask

  task automatic test_x0();
    set_inputs(32'h0000_01B3, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    checks++; if (RD1E !== 32'd0 || RD2E !== 32'd0) begin errors++;
      $display("FAIL x0_same_cycle: got %h/%h want 0", RD1E, RD2E); end
    set_inputs(32'h0000_01B3, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (RD1E !== 32'd0 || RD1E_n !== 32'd0) begin errors++;
      $display("FAIL x0_read: got %h/%h want 0", RD1E, RD1E_n); end
  endtask

  task automatic test_imm();
    set_inputs(32'hFE00_0CE3, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (ImmExtE !== 32'hFFFF_FFF8) begin errors++; $display("FAIL beq_imm: got %h want fffffff8", ImmExtE); end
    checks++; if (BranchE !== 1'b1 || ALUControlE !== 4'b0001) begin errors++;
      $display("FAIL beq_ctl: got br=%b alu=%b want 1/0001", BranchE, ALUControlE); end
    set_inputs(32'hABCD_E237, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (ImmExtE !== 32'hABCD_E000) begin errors++; $display("FAIL lui_imm: got %h want abcde000", ImmExtE); end
    checks++; if (ALUControlE !== 4'b1010) begin errors++; $display("FAIL lui_alu: got %b want 1010", ALUControlE); end
    checks++; if (e_bus !== exp_bus) begin errors++; $display("FAIL lui_bus: got %h want %h", e_bus, exp_bus); end
  endtask

  task automatic test_flush();
    set_inputs(32'h0050_A023, 1'b1, 1'b1, 5'd9, 32'h5555_AAAA);
    tick();
    checks++; if (MemWriteE !== 1'b0) begin errors++; $display("FAIL flush_memw: got %b want 0", MemWriteE); end
    checks++; if (e_bus !== '0 || e_bus_n !== '0) begin errors++;
      $display("FAIL flush_bus: got %h / %h want 0", e_bus, e_bus_n); end
    set_inputs(32'h0004_80B3, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (RD1E !== 32'h5555_AAAA) begin errors++; $display("FAIL flush_wb: got %h want 5555aaaa", RD1E); end
  endtask

  task automatic test_reset_midrun();
    set_inputs(32'h0002_80B3, 1'b0, 1'b1, 5'd5, 32'hCAFE_0005);
    tick();
    checks++; if (RegWriteE !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b want 1", RegWriteE); end
    #2;
    RST = 1'b0;
    #1;
    checks++; if (e_bus !== '0 || e_bus_n !== '0) begin errors++;
      $display("FAIL mid_async: got %h / %h want 0", e_bus, e_bus_n); end
    clear_model();
    @(negedge CLK);
    RST = 1'b1;
    set_inputs(32'h0002_80B3, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (RD1E !== 32'd0) begin errors++; $display("FAIL mid_x5: got %h want 0", RD1E); end
    checks++; if (e_bus !== exp_bus) begin errors++; $display("FAIL mid_bus: got %h want %h", e_bus, exp_bus); end
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    logic [31:0] instr;
    logic [6:0] op;
    logic we, flush;
    logic [4:0] rd;
    bit known;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    for (int n = 0; n < 300; n++) begin
      instr = $urandom();
      if ($urandom_range(0, 9) == 0) begin
        do begin
          op = 7'($urandom_range(0, 127));
          known = 1'b0;
          for (int k = 0; k < 9; k++) if (ops[k] == op) known = 1'b1;
        end while (known);
      end else begin
        op = ops[$urandom_range(0, 8)];
      end
      instr[6:0] = op;
      if ((op == 7'h33 || op == 7'h13) && $urandom_range(0, 1) == 1)
        instr[31:25] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
      we = $urandom_range(0, 1) == 1;
      rd = $urandom_range(0, 3) == 0 ? instr[19:15] : 5'($urandom_range(0, 31));
      flush = $urandom_range(0, 9) == 0;
      set_inputs(instr, flush, we, rd, $urandom());
      #1;
      checks++; if (Rs1D !== instr[19:15] || Rs2D !== instr[24:20]) begin errors++;
        $display("FAIL rnd_rsD: got %0d/%0d want %0d/%0d", Rs1D, Rs2D, instr[19:15], instr[24:20]); end
      tick();
      checks++; if (e_bus !== exp_bus) begin errors++;
        $display("FAIL rnd_bus instr=%h: got %h want %h", instr, e_bus, exp_bus); end
      checks++; if (e_bus_n !== exp_bus_n) begin errors++;
        $display("FAIL rnd_bus_nb instr=%h: got %h want %h", instr, e_bus_n, exp_bus_n); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    InstrD = '0; PCD = '0; PCPlus4D = '0; FlushE = 1'b0;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_imm();
    test_flush();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have parameter WB_BYPASS, default 1, meaning a same-cycle writeback to the source register is forwarded to RD1/RD2.
REQ-002 Ports SHALL be as follows, one per line:
  CLK  in  1  single clock, all state on rising edge
  RST  in  1  asynchronous active-low reset
  InstrD  in  32  instruction from fetch pipeline register
  PCD  in  32  PC of InstrD
  PCPlus4D  in  32  PC+4 of InstrD
  FlushE  in  1  clear ID/EX register (bubble) at next edge
  RegWriteW  in  1  writeback enable
  RdW  in  5  writeback destination
  ResultW  in  32  writeback data
  Rs1D, Rs2D  out  5  source fields of InstrD, combinational, to hazard unit
  RD1E, RD2E  out  32  registered operands
  ImmExtE  out  32  registered sign-extended immediate
  PCE, PCPlus4E  out  32  registered PC, PC+4
  Rs1E, Rs2E, RdE  out  5  registered register fields
  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE  out  1  registered controls
  ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
  ALUControlE  out  4  registered ALU operation
  Funct3E  out  3  registered funct3 (branch condition, load/store width)

Function
REQ-003 Register file SHALL be 32x32; x0 reads 0 always; writes with RdW=0 ignored.
REQ-004 Write SHALL occur on rising CLK when RegWriteW=1; reads combinational.
REQ-005 With WB_BYPASS=1, RegWriteW=1 and RdW=Rs1D (or Rs2D), RdW!=0, the read SHALL return ResultW in the same cycle; with WB_BYPASS=0, the old value.
REQ-006 Immediates SHALL be: I inst[31:20]; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; U {inst[31:12],12'b0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; all sign-extended from bit 31.
REQ-007 ALUControl encoding SHALL be ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASSB 1010.
REQ-008 Decode per opcode SHALL be: OP (0110011) funct3/funct7[5] to ALU op, RegWrite; OP-IMM (0010011) same with ALUSrcB=1, SUB never selected, SRAI by funct7[5]; LOAD (0000011) ADD, ALUSrcB, ResultSrc 01, RegWrite; STORE (0100011) ADD, ALUSrcB, MemWrite; BRANCH (1100011) SUB, Branch; JAL (1101111) Jump, ResultSrc 10, RegWrite; JALR (1100111) Jump, ALUSrcB, ADD, ResultSrc 10, RegWrite; LUI (0110111) PASSB, ALUSrcB, RegWrite; AUIPC (0010111) ALUSrcA=1 (PC), ALUSrcB, ADD, RegWrite.
REQ-009 Unknown opcodes SHALL decode as bubble: RegWrite, MemWrite, Jump, Branch all 0.
REQ-010 ID/EX register SHALL capture all E outputs every rising edge; latency one cycle from InstrD to E outputs.
REQ-011 FlushE=1 SHALL load all E outputs with 0 at the edge (bubble), regardless of InstrD.
REQ-012 Simultaneous FlushE and writeback SHALL both take effect: register file written, ID/EX cleared.

Reset
REQ-013 RST low SHALL immediately clear all E outputs and all 32 registers to 0, independent of CLK.
REQ-014 Rs1D/Rs2D SHALL remain combinational from InstrD during reset.
REQ-015 Release of RST SHALL be synchronised externally; first capture occurs on first edge with RST high.

Structure
REQ-016 Opcode constants, ALUControl and ResultSrc encodings SHALL reside in shared package rv32i_pkg, also used by execute stage.
REQ-017 Register file SHALL be a sub-module regfile; decoder and immediate generator remain in id_stage.

Verification
REQ-018 Reset: RST low mid-run with RegWriteE=1 -> all E outputs 0 at once; read of x5 after release = 0.
REQ-019 Write/read: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF; next cycle InstrD=add x1,x5,x0 -> RD1E=0xDEADBEEF, ALUControlE=0000, RegWriteE=1, RdE=1.
REQ-020 Bypass: same-cycle write x7=0x12345678 and InstrD reading x7 -> RD1E=0x12345678 (WB_BYPASS=1), old value (WB_BYPASS=0).
REQ-021 x0: write RdW=0, ResultW=0xFFFFFFFF -> subsequent read of x0 = 0.
REQ-022 Immediates: beq with offset -8 -> ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=0001; lui 0xABCDE -> ImmExtE=0xABCDE000, ALUControlE=1010.
REQ-023 Flush: FlushE=1 with sw in InstrD -> next cycle MemWriteE=0, all E outputs 0.
